// File: rtl/mprj_io_cfg_loader_pkg.sv
// mprj_cfg_pkg: shared types and constants for the GPIO pad configuration loader.
//   - cfg_state_t : loader sequencer states
//   - OFS_*       : bit offsets of the fields inside one 13-bit pad word
//   - CFG_DEFAULT : power-on word for a pad that the management core owns
package mprj_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_SHIFT,
    ST_LOAD,
    ST_FIN
  } cfg_state_t;

  localparam int CFG_WORD_BITS   = 13;

  localparam int OFS_MGMT_EN     = 0;
  localparam int OFS_OEB         = 1;
  localparam int OFS_HOLDOVER    = 2;
  localparam int OFS_INP_DIS     = 3;
  localparam int OFS_IB_MODE_SEL = 4;
  localparam int OFS_ANALOG_EN   = 5;
  localparam int OFS_ANALOG_SEL  = 6;
  localparam int OFS_ANALOG_POL  = 7;
  localparam int OFS_SLOW_SEL    = 8;
  localparam int OFS_VTRIP_SEL   = 9;
  localparam int OFS_DM          = 10;
  localparam int DM_BITS         = 3;

  // dm=3'b110, management enabled, output buffer disabled, everything else off.
  localparam logic [CFG_WORD_BITS-1:0] CFG_DEFAULT = 13'h1803;

endpackage

// File: rtl/mprj_io_cfg_loader_if.sv
// mprj_io_cfg_loader_if: control, register-file read and pad-chain signals of the loader.
//   start/busy/done        : load request handshake
//   cfg_rd_addr/cfg_rd_data : pad word read from the housekeeping register file
//   serial_*               : daisy-chained pad control shift register
// modport master = loader side, modport slave = management/housekeeping side.
interface mprj_io_cfg_loader_if #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13
);
  localparam int AW = $clog2(NUM_PADS);

  logic                start;
  logic                busy;
  logic                done;
  logic [AW-1:0]       cfg_rd_addr;
  logic [CFG_BITS-1:0] cfg_rd_data;
  logic                serial_resetn;
  logic                serial_clock;
  logic                serial_data;
  logic                serial_load;

  modport master (
    input  start, cfg_rd_data,
    output busy, done, cfg_rd_addr,
           serial_resetn, serial_clock, serial_data, serial_load
  );

  modport slave (
    output start, cfg_rd_data,
    input  busy, done, cfg_rd_addr,
           serial_resetn, serial_clock, serial_data, serial_load
  );
endinterface

// File: rtl/mprj_io_cfg_loader_serial_clk_gen.sv
// serial_clk_gen: bit-period timer for the pad chain shift clock.
//   clock, reset : system clock, async active-high reset
//   en           : count while high; held at the start of a period while low
//   phase_hi     : registered shift clock, high for the last CLK_DIV/2 cycles of a period
//   bit_end      : strobe in the last cycle of each period
module serial_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic phase_hi,
  output logic bit_end
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF    = CW'(CLK_DIV / 2);

  // cycles left in the current period, terminal count 0
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = CNT_MAX;
    if (en && (cnt != '0)) cnt_nxt = cnt - 1'b1;
  end

  // phase_hi is computed from the next count so the flop already holds the
  // value for the coming cycle; the chain clock then comes straight off a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= CNT_MAX;
      phase_hi <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      phase_hi <= en && (cnt_nxt < HALF);
    end
  end

  assign bit_end = en && (cnt == '0);

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader: serially loads one configuration word per GPIO pad into the
// pad control daisy chain, highest pad first, MSB first, then pulses serial_load.
//   clock, reset : system clock, async active-high reset
//   bus (master) : start/busy/done handshake, register-file read port, chain outputs
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; chain reset released
// ST_CRST  | serial_resetn low for CLK_DIV cycles
// ST_SHIFT | NUM_PADS*CFG_BITS bit periods of CLK_DIV cycles each
// ST_LOAD  | serial_load high for CLK_DIV cycles, shift clock parked low
// ST_FIN   | done pulse, busy already low
module mprj_io_cfg_loader
  import mprj_cfg_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4    // even, >= 2
) (
  input  logic                  clock,
  input  logic                  reset,
  mprj_io_cfg_loader_if.master  bus
);
  localparam int AW = $clog2(NUM_PADS);
  localparam int BW = $clog2(CFG_BITS);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [AW-1:0] PAD_MAX = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(CFG_BITS - 1);
  localparam logic [CW-1:0] TMR_MAX = CW'(CLK_DIV - 1);

  cfg_state_t    state;
  logic          busy_q;
  logic          done_q;
  logic          resetn_q;
  logic          load_q;
  logic          data_q;
  logic [AW-1:0] pad_cnt;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] tmr;
  logic          last_bit;
  logic          phase_hi;
  logic          bit_end;
  logic          take_bit;

  serial_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clock    (clock),
    .reset    (reset),
    .en       (state == ST_SHIFT),
    .phase_hi (phase_hi),
    .bit_end  (bit_end)
  );

  // serial_data is captured at the edge that opens each bit period, so the
  // pad/bit counters always point at the bit about to be launched, one ahead
  // of the bit currently on serial_data. That keeps the register-file read
  // address settled for a full cycle before its data is sampled.
  assign take_bit = ((state == ST_CRST) && (tmr == '0)) ||
                    ((state == ST_SHIFT) && bit_end && !last_bit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resetn_q <= 1'b0;
      load_q   <= 1'b0;
      data_q   <= 1'b0;
      pad_cnt  <= PAD_MAX;
      bit_cnt  <= BIT_MAX;
      tmr      <= '0;
      last_bit <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          resetn_q <= 1'b1;
          if (bus.start) begin
            state    <= ST_CRST;
            busy_q   <= 1'b1;
            resetn_q <= 1'b0;
            tmr      <= TMR_MAX;
            pad_cnt  <= PAD_MAX;
            bit_cnt  <= BIT_MAX;
            last_bit <= 1'b0;
          end
        end
        ST_CRST: begin
          if (tmr == '0) begin
            state    <= ST_SHIFT;
            resetn_q <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_end && last_bit) begin
            state  <= ST_LOAD;
            load_q <= 1'b1;
            tmr    <= TMR_MAX;
          end
        end
        ST_LOAD: begin
          if (tmr == '0) begin
            state  <= ST_FIN;
            load_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (take_bit) begin
        data_q <= bus.cfg_rd_data[bit_cnt];
        if (bit_cnt != '0) begin
          bit_cnt <= bit_cnt - 1'b1;
        end else begin
          bit_cnt <= BIT_MAX;
          if (pad_cnt != '0) begin
            pad_cnt <= pad_cnt - 1'b1;
          end else begin
            // pad 0 bit 0 launched: park the address back on the top pad
            pad_cnt  <= PAD_MAX;
            last_bit <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cfg_rd_addr   = pad_cnt;
  assign bus.serial_resetn = resetn_q;
  assign bus.serial_clock  = phase_hi;
  assign bus.serial_data   = data_q;
  assign bus.serial_load   = load_q;

endmodule
